// File: rtl/ysyx_25020042_pkg.sv
// Shared types for the data-memory arbiter: FSM states,
// request owner encoding and default widths.
package ysyx_25020042_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_t;

endpackage

// File: rtl/ysyx_25020042_arb_prio.sv
// Grant logic for the shared memory port: LSU first, with a
// saturating starvation counter that forces an IFU turn.
module ysyx_25020042_arb_prio
   import ysyx_25020042_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   idle,
   input  logic   ifu_req_valid,
   input  logic   lsu_req_valid,
   output logic   ifu_req_ready,
   output logic   lsu_req_ready,
   output logic   grant,
   output owner_t grant_owner
);

   localparam logic [CNT_W-1:0] MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt;
   logic             lsu_win;
   logic             ifu_win;

   // Ready is also gated by reset so nothing looks accepted while held.
   always_comb begin
      lsu_win       = lsu_req_valid &&
                      !(ifu_req_valid && starve_cnt == MAX);
      ifu_win       = ifu_req_valid && !lsu_win;
      lsu_req_ready = idle && rst && lsu_win;
      ifu_req_ready = idle && rst && ifu_win;
      grant         = lsu_req_ready || ifu_req_ready;
      grant_owner   = lsu_req_ready ? OWN_LSU : OWN_IFU;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (lsu_req_ready) begin
         if (!ifu_req_valid) begin
            starve_cnt <= '0;
         end else if (starve_cnt != MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end else if (ifu_req_ready) begin
         starve_cnt <= '0;
      end
   end

endmodule

// File: rtl/ysyx_25020042_mem_arbiter.sv
// Single data-memory port shared by fetch and load/store;
// one transaction at a time through IDLE/ACCESS/WAIT/RESP.
module ysyx_25020042_mem_arbiter
   import ysyx_25020042_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_rsp_valid,
   output logic [DATA_W-1:0]   ifu_rsp_data,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic                lsu_wen,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_rsp_valid,
   output logic [DATA_W-1:0]   lsu_rsp_data,
   output logic                mem_req,
   output logic                mem_wen,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   localparam int MASK_W = DATA_W / 8;
   localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT - 1);

   state_t              state;
   state_t              state_n;
   owner_t              owner_q;
   owner_t              grant_owner;
   logic                grant;
   logic [ADDR_W-1:0]   addr_q;
   logic                wen_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [MASK_W-1:0]   wmask_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [CNT_W-1:0]    lat_cnt;

   ysyx_25020042_arb_prio #(
      .STARVE_MAX (STARVE_MAX)
   ) u_prio (
      .clk           (clk),
      .rst           (rst),
      .idle          (state == IDLE),
      .ifu_req_valid (ifu_req_valid),
      .lsu_req_valid (lsu_req_valid),
      .ifu_req_ready (ifu_req_ready),
      .lsu_req_ready (lsu_req_ready),
      .grant         (grant),
      .grant_owner   (grant_owner)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n       = state;
      busy          = 1'b1;
      mem_req       = 1'b0;
      mem_wen       = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      mem_wmask     = '0;
      ifu_rsp_valid = 1'b0;
      ifu_rsp_data  = '0;
      lsu_rsp_valid = 1'b0;
      lsu_rsp_data  = '0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (grant) state_n = ACCESS;
         end
         ACCESS: begin
            mem_req   = 1'b1;
            mem_wen   = wen_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_wmask = wmask_q;
            state_n   = WAIT;
         end
         WAIT: begin
            mem_wen   = wen_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_wmask = wmask_q;
            if (lat_cnt == '0) state_n = RESP;
         end
         RESP: begin
            if (owner_q == OWN_LSU) begin
               lsu_rsp_valid = 1'b1;
               lsu_rsp_data  = rdata_q;
            end else begin
               ifu_rsp_valid = 1'b1;
               ifu_rsp_data  = rdata_q;
            end
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Write payload is zeroed at capture so loads never drive it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_q <= OWN_IFU;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
      end else if (grant) begin
         owner_q <= grant_owner;
         if (grant_owner == OWN_LSU) begin
            addr_q  <= lsu_addr;
            wen_q   <= lsu_wen;
            wdata_q <= lsu_wen ? lsu_wdata : '0;
            wmask_q <= lsu_wen ? lsu_wmask : '0;
         end else begin
            addr_q  <= ifu_addr;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lat_cnt <= '0;
         rdata_q <= '0;
      end else begin
         if (state == ACCESS) begin
            lat_cnt <= LAT_INIT;
         end else if (state == WAIT && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
         end
         if (state == WAIT && lat_cnt == '0) begin
            rdata_q <= wen_q ? '0 : mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_25020042_mem_arbiter.sv
// Directed bench: table of single transactions at MEM_LAT=1
// plus hand sequences for starvation, latency, reset, payload.
module tb_ysyx_25020042_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid;
   logic [31:0] ifu_addr;
   logic        lsu_req_valid;
   logic        lsu_wen;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic [3:0]  lsu_wmask;
   logic [31:0] mem_rdata;

   logic        a_ifu_rdy, a_ifu_rsp, a_lsu_rdy, a_lsu_rsp;
   logic [31:0] a_ifu_data, a_lsu_data, a_mem_addr, a_mem_wdata;
   logic        a_mem_req, a_mem_wen, a_busy;
   logic [3:0]  a_mem_wmask;

   logic        b_ifu_rdy, b_ifu_rsp, b_lsu_rdy, b_lsu_rsp;
   logic [31:0] b_ifu_data, b_lsu_data, b_mem_addr, b_mem_wdata;
   logic        b_mem_req, b_mem_wen, b_busy;
   logic [3:0]  b_mem_wmask;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ysyx_25020042_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)
   ) dut1 (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(a_ifu_rdy),
      .ifu_addr(ifu_addr), .ifu_rsp_valid(a_ifu_rsp),
      .ifu_rsp_data(a_ifu_data),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(a_lsu_rdy),
      .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
      .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_rsp_valid(a_lsu_rsp), .lsu_rsp_data(a_lsu_data),
      .mem_req(a_mem_req), .mem_wen(a_mem_wen),
      .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_wmask(a_mem_wmask), .mem_rdata(mem_rdata),
      .busy(a_busy)
   );

   ysyx_25020042_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)
   ) dut3 (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(b_ifu_rdy),
      .ifu_addr(ifu_addr), .ifu_rsp_valid(b_ifu_rsp),
      .ifu_rsp_data(b_ifu_data),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(b_lsu_rdy),
      .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
      .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_rsp_valid(b_lsu_rsp), .lsu_rsp_data(b_lsu_data),
      .mem_req(b_mem_req), .mem_wen(b_mem_wen),
      .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_wmask(b_mem_wmask), .mem_rdata(mem_rdata),
      .busy(b_busy)
   );

   typedef struct {
      logic        lsu;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] rdata;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_wmask;
      logic [31:0] exp_rsp;
   } vec_t;

   vec_t tbl[5];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act,
                       input logic exp);
      chk(nm, 32'(act), 32'(exp));
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      ifu_req_valid = 1'b0;
      lsu_req_valid = 1'b0;
      lsu_wen       = 1'b0;
      ifu_addr      = '0;
      lsu_addr      = '0;
      lsu_wdata     = '0;
      lsu_wmask     = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      cyc();
      cyc();
      rst = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   w;
      logic exp_l;

      tbl[0] = '{1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0,
                 32'h0010_0073, 32'h0, 4'h0, 32'h0010_0073};
      tbl[1] = '{1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'b0011,
                 32'h1234_5678, 32'hDEAD_BEEF, 4'b0011, 32'h0};
      tbl[2] = '{1'b1, 1'b0, 32'h8000_1004, 32'h9999_9999, 4'hF,
                 32'hCAFE_F00D, 32'h0, 4'h0, 32'hCAFE_F00D};
      tbl[3] = '{1'b0, 1'b0, 32'h8000_0004, 32'h0, 4'h0,
                 32'h0000_0013, 32'h0, 4'h0, 32'h0000_0013};
      tbl[4] = '{1'b1, 1'b1, 32'h8000_1FFC, 32'h0BAD_F00D, 4'b1100,
                 32'hFFFF_FFFF, 32'h0BAD_F00D, 4'b1100, 32'h0};

      // reset state
      mem_rdata = '0;
      idle_inputs();
      rst = 1'b0;
      cyc();
      #1;
      chk1("rst_busy", a_busy, 1'b0);
      chk1("rst_mem_req", a_mem_req, 1'b0);
      chk("rst_mem_addr", a_mem_addr, 32'h0);
      chk1("rst_ifu_rsp", a_ifu_rsp, 1'b0);
      chk1("rst_lsu_rsp", a_lsu_rsp, 1'b0);
      cyc();
      rst = 1'b1;

      // table of single transactions, MEM_LAT = 1
      for (int i = 0; i < 5; i++) begin
         v = tbl[i];
         ifu_req_valid = !v.lsu;
         lsu_req_valid = v.lsu;
         ifu_addr      = v.addr;
         lsu_addr      = v.addr;
         lsu_wen       = v.wen;
         lsu_wdata     = v.wdata;
         lsu_wmask     = v.wmask;
         mem_rdata     = v.rdata;
         #1;
         chk1("v_ifu_rdy", a_ifu_rdy, !v.lsu);
         chk1("v_lsu_rdy", a_lsu_rdy, v.lsu);
         chk1("v_busy_c0", a_busy, 1'b0);
         cyc();
         ifu_req_valid = 1'b0;
         lsu_req_valid = 1'b0;
         ifu_addr      = '1;
         lsu_addr      = '1;
         lsu_wen       = !v.wen;
         lsu_wdata     = '1;
         lsu_wmask     = '1;
         #1;
         chk1("v_mem_req_c1", a_mem_req, 1'b1);
         chk("v_mem_addr_c1", a_mem_addr, v.addr);
         chk1("v_mem_wen_c1", a_mem_wen, v.wen);
         chk("v_mem_wdata_c1", a_mem_wdata, v.exp_wdata);
         chk("v_mem_wmask_c1", 32'(a_mem_wmask), 32'(v.exp_wmask));
         chk1("v_busy_c1", a_busy, 1'b1);
         cyc();
         #1;
         chk1("v_mem_req_c2", a_mem_req, 1'b0);
         chk("v_mem_addr_c2", a_mem_addr, v.addr);
         chk1("v_mem_wen_c2", a_mem_wen, v.wen);
         chk1("v_early_rsp", a_ifu_rsp | a_lsu_rsp, 1'b0);
         cyc();
         #1;
         chk1("v_ifu_rsp", a_ifu_rsp, !v.lsu);
         chk1("v_lsu_rsp", a_lsu_rsp, v.lsu);
         chk("v_rsp_data", v.lsu ? a_lsu_data : a_ifu_data, v.exp_rsp);
         chk("v_other_data", v.lsu ? a_ifu_data : a_lsu_data, 32'h0);
         chk1("v_mem_wen_c3", a_mem_wen, 1'b0);
         chk1("v_busy_c3", a_busy, 1'b1);
         cyc();
         #1;
         chk1("v_busy_c4", a_busy, 1'b0);
         chk1("v_rsp_c4", a_ifu_rsp | a_lsu_rsp, 1'b0);
      end

      // starvation: both valid continuously
      do_reset();
      ifu_req_valid = 1'b1;
      lsu_req_valid = 1'b1;
      lsu_wen       = 1'b0;
      ifu_addr      = 32'h8000_0100;
      lsu_addr      = 32'h8000_2000;
      for (int g = 0; g < 6; g++) begin
         exp_l = (g != 4);
         mem_rdata = exp_l ? 32'h2222_0000 + g : 32'h1111_0000 + g;
         w = 0;
         #1;
         while (!(a_ifu_rdy || a_lsu_rdy) && w < 8) begin
            cyc();
            #1;
            w++;
         end
         if (w >= 8) chk1("t3_ready_timeout", 1'b0, 1'b1);
         chk1("t3_lsu_grant", a_lsu_rdy, exp_l);
         chk1("t3_ifu_grant", a_ifu_rdy, !exp_l);
         cyc();
         cyc();
         cyc();
         #1;
         chk1("t3_lsu_rsp", a_lsu_rsp, exp_l);
         chk1("t3_ifu_rsp", a_ifu_rsp, !exp_l);
         chk("t3_rsp_data", exp_l ? a_lsu_data : a_ifu_data, mem_rdata);
         cyc();
      end
      idle_inputs();

      // MEM_LAT = 3: sampling point and address stability
      do_reset();
      lsu_req_valid = 1'b1;
      lsu_addr      = 32'h8000_3000;
      mem_rdata     = 32'hAAAA_0000;
      #1;
      chk1("t4_lsu_rdy", b_lsu_rdy, 1'b1);
      for (int c = 1; c <= 6; c++) begin
         cyc();
         lsu_req_valid = 1'b0;
         lsu_addr      = 32'h0BAD_0000;
         mem_rdata     = 32'hAAAA_0000 + c;
         #1;
         if (c == 1) chk1("t4_mem_req_c1", b_mem_req, 1'b1);
         if (c >= 2 && c <= 4) begin
            chk1("t4_mem_req_wait", b_mem_req, 1'b0);
            chk1("t4_rsp_wait", b_lsu_rsp, 1'b0);
         end
         if (c <= 4) chk("t4_mem_addr", b_mem_addr, 32'h8000_3000);
         if (c == 5) begin
            chk1("t4_lsu_rsp", b_lsu_rsp, 1'b1);
            chk("t4_rsp_data", b_lsu_data, 32'hAAAA_0004);
         end
         if (c == 6) chk1("t4_busy_end", b_busy, 1'b0);
      end

      // reset asserted in WAIT
      do_reset();
      ifu_req_valid = 1'b1;
      ifu_addr      = 32'h8000_0200;
      lsu_req_valid = 1'b1;
      lsu_addr      = 32'h8000_5000;
      mem_rdata     = 32'h0000_0077;
      #1;
      chk1("t5_lsu_rdy", b_lsu_rdy, 1'b1);
      cyc();
      idle_inputs();
      #1;
      chk1("t5_mem_req", b_mem_req, 1'b1);
      cyc();
      #1;
      chk1("t5_busy_wait", b_busy, 1'b1);
      rst = 1'b0;
      #1;
      chk1("t5_rst_busy", b_busy, 1'b0);
      chk("t5_rst_mem_addr", b_mem_addr, 32'h0);
      chk1("t5_rst_rsp", b_lsu_rsp | b_ifu_rsp, 1'b0);
      chk("t5_rst_starve", 32'(dut3.u_prio.starve_cnt), 32'h0);
      cyc();
      cyc();
      rst = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk1("t5_no_rsp", b_lsu_rsp | b_ifu_rsp, 1'b0);
         cyc();
      end
      ifu_req_valid = 1'b1;
      ifu_addr      = 32'h8000_0300;
      mem_rdata     = 32'h0000_0297;
      #1;
      chk1("t5_ifu_rdy", b_ifu_rdy, 1'b1);
      for (int c = 1; c <= 5; c++) begin
         cyc();
         ifu_req_valid = 1'b0;
         #1;
      end
      chk1("t5_ifu_rsp", b_ifu_rsp, 1'b1);
      chk("t5_ifu_data", b_ifu_data, 32'h0000_0297);

      // payload changes while held off by an LSU transaction
      do_reset();
      lsu_req_valid = 1'b1;
      lsu_addr      = 32'h8000_4000;
      #1;
      chk1("t6_lsu_rdy", a_lsu_rdy, 1'b1);
      cyc();
      lsu_req_valid = 1'b0;
      ifu_req_valid = 1'b1;
      ifu_addr      = 32'h8000_0A00;
      #1;
      chk1("t6_ifu_hold_c1", a_ifu_rdy, 1'b0);
      cyc();
      ifu_addr = 32'h8000_0B00;
      #1;
      chk1("t6_ifu_hold_c2", a_ifu_rdy, 1'b0);
      cyc();
      ifu_addr = 32'h8000_0C00;
      #1;
      chk1("t6_ifu_hold_c3", a_ifu_rdy, 1'b0);
      chk1("t6_lsu_rsp", a_lsu_rsp, 1'b1);
      cyc();
      ifu_addr = 32'h8000_0D00;
      #1;
      chk1("t6_ifu_rdy", a_ifu_rdy, 1'b1);
      cyc();
      ifu_req_valid = 1'b0;
      ifu_addr      = 32'h8000_0E00;
      #1;
      chk1("t6_mem_req", a_mem_req, 1'b1);
      chk("t6_mem_addr", a_mem_addr, 32'h8000_0D00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
